param_voting_machine: RTL and testbench

- Parametrised successor to the fixed 4-candidate voting machine: N_CAND buttons, CNT_W-bit tally per candidate.
- Adds an officer-armed one-ballot-per-voter FSM, multi-press rejection, saturating counters, registered winner/tie detection and a selectable result display.
- Top-level block between raw push buttons and the LED/display driver.

---
 rtl/vm_pkg.sv | 19 +
 rtl/vm_button_sync.sv | 63 ++++++
 rtl/param_voting_machine.sv | 146 ++++++++++++++
 tb/tb_param_voting_machine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared types and helpers for the parametrised voting machine.
package vm_pkg;

   typedef enum logic [1:0] {StIdle, StArmed, StAck} vm_state_e;

   localparam int unsigned VM_DEF_CNT_W  = 8;
   localparam int unsigned VM_DEF_N_CAND = 4;

   // Callers zero-extend their press vector to 16 bits (max candidate count).
   function automatic logic onehot_chk(input logic [15:0] vec);
      int unsigned ones;
      ones = 0;
      for (int i = 0; i < 16; i++) begin
         ones += {31'd0, vec[i]};
      end
      return (ones == 1);
   endfunction

endpackage

// File: rtl/vm_button_sync.sv
// One raw button -> 2-flop synchroniser, optional debounce (VM_DEBOUNCE_EN), rising-edge pulse.
module vm_button_sync #(
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic press_o
);

   logic [1:0] sync_q;
   logic       level;
   logic       prev_q;

   if (DEB_CYCLES < 1) begin : g_bad_deb
      $error("DEB_CYCLES must be at least 1");
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], btn_i};
      end
   end

`ifdef VM_DEBOUNCE_EN
   localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

   logic [CntW-1:0] cnt_q;
   logic            filt_q;

   // Filtered level follows the synchroniser only after DEB_CYCLES stable samples.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else if (sync_q[1] == filt_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
         cnt_q  <= '0;
         filt_q <= sync_q[1];
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign level = filt_q;
`else
   assign level = sync_q[1];
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= level;
      end
   end

   assign press_o = level & ~prev_q;

endmodule

// File: rtl/param_voting_machine.sv
// Parametrised voting machine: armed one-ballot FSM, saturating tallies, winner/tie and display.
// Build option: define VM_DEBOUNCE_EN to insert a DEB_CYCLES debounce filter per button.
module param_voting_machine
   import vm_pkg::*;
#(
   parameter int unsigned N_CAND     = VM_DEF_N_CAND,
   parameter int unsigned CNT_W      = VM_DEF_CNT_W,
   parameter int unsigned SEL_W      = $clog2(N_CAND),
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mode,
   input  logic              voter_arm,
   input  logic [N_CAND-1:0] button,
   input  logic [SEL_W-1:0]  sel,
   output logic              armed,
   output logic              vote_ack,
   output logic              vote_err,
   output logic [CNT_W-1:0]  disp,
   output logic [SEL_W-1:0]  winner,
   output logic              tie,
   output logic              sat
);

   if (N_CAND < 2 || N_CAND > 16) begin : g_bad_ncand
      $error("N_CAND must be in 2..16");
   end

   logic [N_CAND-1:0] press;
   vm_state_e         state_q, state_d;
   logic              inc_en;
   logic              err_d, err_q;
   logic [CNT_W-1:0]  tally_q [N_CAND];
   logic              sat_q;
   logic [CNT_W-1:0]  disp_d, disp_q;
   logic [SEL_W-1:0]  winner_d, winner_q;
   logic              tie_d, tie_q;

   for (genvar i = 0; i < N_CAND; i++) begin : g_btn
      vm_button_sync #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_sync (
         .clk_i  (clk),
         .rst_i  (reset),
         .btn_i  (button[i]),
         .press_o(press[i])
      );
   end

   always_comb begin
      state_d = state_q;
      inc_en  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (voter_arm && !mode) state_d = StArmed;
         end
         StArmed: begin
            if (mode) begin
               state_d = StIdle;
            end else if (onehot_chk(16'(press))) begin
               state_d = StAck;
               inc_en  = 1'b1;
            end else if (press != '0) begin
               err_d = 1'b1;
            end
         end
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   // A vote on a full tally is still accepted but only raises the sticky flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CAND; i++) tally_q[i] <= '0;
         sat_q <= 1'b0;
      end else if (inc_en) begin
         for (int i = 0; i < N_CAND; i++) begin
            if (press[i]) begin
               if (tally_q[i] == {CNT_W{1'b1}}) sat_q <= 1'b1;
               else tally_q[i] <= tally_q[i] + 1'b1;
            end
         end
      end
   end

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      logic [CNT_W-1:0] best;
      int unsigned      n_best;
      best     = tally_q[0];
      winner_d = '0;
      for (int i = 1; i < N_CAND; i++) begin
         if (tally_q[i] > best) begin
            best     = tally_q[i];
            winner_d = SEL_W'(i);
         end
      end
      n_best = 0;
      for (int i = 0; i < N_CAND; i++) begin
         if (tally_q[i] == best) n_best++;
      end
      tie_d = (best != '0) && (n_best >= 2);
   end

   // Out-of-range sel matches no candidate and leaves the display at zero.
   always_comb begin
      disp_d = '0;
      for (int i = 0; i < N_CAND; i++) begin
         if (mode && sel == SEL_W'(i)) disp_d = tally_q[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_q   <= '0;
         winner_q <= '0;
         tie_q    <= 1'b0;
      end else begin
         disp_q   <= disp_d;
         winner_q <= winner_d;
         tie_q    <= tie_d;
      end
   end

   assign armed    = (state_q == StArmed);
   assign vote_ack = (state_q == StAck);
   assign vote_err = err_q;
   assign disp     = disp_q;
   assign winner   = winner_q;
   assign tie      = tie_q;
   assign sat      = sat_q;

endmodule

// File: tb/tb_param_voting_machine.sv
// Scoreboard bench for param_voting_machine (N_CAND=4, CNT_W=3); honours VM_DEBOUNCE_EN.
module tb_param_voting_machine;

   localparam int NC  = 4;
   localparam int CW  = 3;
   localparam int SW  = 2;
   localparam int DEB = 16;
`ifdef VM_DEBOUNCE_EN
   localparam int Extra = DEB;
`else
   localparam int Extra = 0;
`endif
   localparam int Lat = 3 + Extra;
   localparam int EvAck = 0;
   localparam int EvErr = 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          mode = 1'b0;
   logic          voter_arm = 1'b0;
   logic [NC-1:0] button = '0;
   logic [SW-1:0] sel = '0;
   logic          armed, vote_ack, vote_err, tie, sat;
   logic [CW-1:0] disp;
   logic [SW-1:0] winner;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   param_voting_machine #(
      .N_CAND    (NC),
      .CNT_W     (CW),
      .SEL_W     (SW),
      .DEB_CYCLES(DEB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .mode     (mode),
      .voter_arm(voter_arm),
      .button   (button),
      .sel      (sel),
      .armed    (armed),
      .vote_ack (vote_ack),
      .vote_err (vote_err),
      .disp     (disp),
      .winner   (winner),
      .tie      (tie),
      .sat      (sat)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Monitor: every ack/err pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (!reset && (vote_ack || vote_err)) begin
         int got;
         checks++;
         got = vote_err ? EvErr : EvAck;
         if (vote_ack && vote_err) begin
            errors++;
            $display("FAIL pulse actual=ack+err required=single");
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pulse actual=%s required=none", got == EvAck ? "ack" : "err");
         end else begin
            int e;
            e = exp_q.pop_front();
            if (got != e) begin
               errors++;
               $display("FAIL pulse actual=%s required=%s", got == EvAck ? "ack" : "err",
                        e == EvAck ? "ack" : "err");
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic arm();
      voter_arm = 1'b1;
      step(1);
      voter_arm = 1'b0;
   endtask

   // ev < 0: no pulse expected.
   task automatic vote(input logic [NC-1:0] m, input int ev);
      if (ev >= 0) exp_q.push_back(ev);
      button = m;
      step(Lat + 1);
      button = '0;
      step(Lat + 2);
   endtask

   task automatic peek(input int idx, input int exp);
      mode = 1'b1;
      sel  = SW'(idx);
      step(1);
      chk($sformatf("disp[%0d]", idx), int'(disp), exp);
      mode = 1'b0;
      step(1);
   endtask

   initial begin
      step(2);
      chk("rst_armed", int'(armed), 0);
      chk("rst_disp", int'(disp), 0);
      chk("rst_winner", int'(winner), 0);
      chk("rst_tie", int'(tie), 0);
      chk("rst_sat", int'(sat), 0);
      reset = 1'b0;
      step(1);

      // Single vote for candidate 2 with latency check.
      arm();
      chk("armed_after_arm", int'(armed), 1);
      exp_q.push_back(EvAck);
      button = 4'b0100;
      step(2 + Extra);
      chk("ack_early", int'(vote_ack), 0);
      step(1);
      chk("ack_k2", int'(vote_ack), 1);
      chk("armed_in_ack", int'(armed), 0);
      button = '0;
      step(Lat + 2);
      peek(2, 1);
      chk("disp_mode0", int'(disp), 0);
      chk("winner_c2", int'(winner), 2);
      chk("tie_c2", int'(tie), 0);
      chk("sat_c2", int'(sat), 0);

      // Multi-press rejected, ballot stays open.
      arm();
      vote(4'b1001, EvErr);
      chk("armed_after_err", int'(armed), 1);
      vote(4'b1000, EvAck);
      peek(0, 0);
      peek(3, 1);
      peek(2, 1);
      chk("winner_23", int'(winner), 2);
      chk("tie_23", int'(tie), 1);

      // Second press without re-arming is ignored.
      arm();
      vote(4'b0010, EvAck);
      vote(4'b0010, -1);
      peek(1, 1);
      chk("winner_123", int'(winner), 1);

      // cand1=2, cand3=2 tie, then cand3 takes the lead one edge after the tally.
      arm();
      vote(4'b0010, EvAck);
      chk("tie_c1_lead", int'(tie), 0);
      arm();
      vote(4'b1000, EvAck);
      chk("winner_tie13", int'(winner), 1);
      chk("tie_13", int'(tie), 1);
      arm();
      exp_q.push_back(EvAck);
      button = 4'b1000;
      step(Lat);
      chk("winner_before_k3", int'(winner), 1);
      step(1);
      chk("winner_after_k3", int'(winner), 3);
      chk("tie_after_k3", int'(tie), 0);
      button = '0;
      step(Lat + 2);

      // Nine votes into a 3-bit tally saturate at 7.
      for (int i = 0; i < 9; i++) begin
         arm();
         vote(4'b0001, EvAck);
      end
      peek(0, 7);
      chk("sat_set", int'(sat), 1);
      chk("winner_sat", int'(winner), 0);

      // voter_arm ignored in result mode; mode=1 cancels an open ballot.
      mode = 1'b1;
      voter_arm = 1'b1;
      step(2);
      chk("arm_in_mode1", int'(armed), 0);
      voter_arm = 1'b0;
      mode = 1'b0;
      step(1);
      arm();
      mode = 1'b1;
      step(1);
      chk("cancel", int'(armed), 0);
      mode = 1'b0;
      vote(4'b0100, -1);
      peek(2, 1);

      // Asynchronous reset mid-ballot.
      arm();
      chk("armed_pre_rst", int'(armed), 1);
      #2 reset = 1'b1;
      #1;
      chk("async_armed", int'(armed), 0);
      chk("async_sat", int'(sat), 0);
      chk("async_winner", int'(winner), 0);
      chk("async_disp", int'(disp), 0);
      step(1);
      reset = 1'b0;
      step(1);
      peek(0, 0);
      peek(3, 0);

`ifdef VM_DEBOUNCE_EN
      // Glitch shorter than the debounce window yields no press.
      arm();
      button = 4'b0001;
      step(3);
      button = '0;
      step(Lat + 20);
      chk("glitch_armed", int'(armed), 1);
      peek(0, 0);
`endif

      step(2);
      chk("pending_events", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
